// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants, stage-operation decode and popcount helper for the MEM/WB pipeline register.
package mem_wb_pipe_pkg;

    localparam logic       RstEnable    = 1'b1;
    localparam logic       WriteEnable  = 1'b1;
    localparam logic       WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [4:0] NOPRegAddr   = 5'b00000;
    localparam logic       Stop         = 1'b1;
    localparam logic       NoStop       = 1'b0;

    localparam int unsigned StallMemBit = 4;
    localparam int unsigned StallWbBit  = 5;

    typedef enum logic [1:0] {
        OpAdvance,
        OpBubble,
        OpHold,
        OpFlush
    } wb_op_e;

    // An illegal stall (wb stalled, mem running) falls through to advance.
    function automatic wb_op_e decode_op(input logic flush, input logic [5:0] stall);
        if (flush == WriteEnable) begin
            return OpFlush;
        end else if (stall[StallMemBit] == Stop && stall[StallWbBit] == NoStop) begin
            return OpBubble;
        end else if (stall[StallMemBit] == NoStop) begin
            return OpAdvance;
        end
        return OpHold;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM-side inputs and WB-side registered outputs of the MEM/WB pipeline register.
interface mem_wb_pipe_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LANES      = 1,
    parameter int unsigned CP0_ADDR_W = 5
);

    logic [LANES-1:0]            mem_valid;
    logic [LANES*REG_ADDR_W-1:0] mem_wd;
    logic [LANES-1:0]            mem_wreg;
    logic [LANES*DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]           mem_hi;
    logic [DATA_W-1:0]           mem_lo;
    logic                        mem_whilo;
    logic                        mem_llbit_we;
    logic                        mem_llbit_value;
    logic                        mem_cp0_we;
    logic [CP0_ADDR_W-1:0]       mem_cp0_waddr;
    logic [DATA_W-1:0]           mem_cp0_data;

    logic [LANES-1:0]            wb_valid;
    logic [LANES*REG_ADDR_W-1:0] wb_wd;
    logic [LANES-1:0]            wb_wreg;
    logic [LANES*DATA_W-1:0]     wb_wdata;
    logic [DATA_W-1:0]           wb_hi;
    logic [DATA_W-1:0]           wb_lo;
    logic                        wb_whilo;
    logic                        wb_llbit_we;
    logic                        wb_llbit_value;
    logic                        wb_cp0_we;
    logic [CP0_ADDR_W-1:0]       wb_cp0_waddr;
    logic [DATA_W-1:0]           wb_cp0_data;

    modport master (
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_llbit_we, mem_llbit_value, mem_cp0_we, mem_cp0_waddr, mem_cp0_data,
        input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr, wb_cp0_data
    );

    modport slave (
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
               mem_llbit_we, mem_llbit_value, mem_cp0_we, mem_cp0_waddr, mem_cp0_data,
        output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr, wb_cp0_data
    );

endinterface

// File: rtl/mem_wb_lane.sv
// One write-back lane of the MEM/WB register: valid, destination, gated write enable and data.
module mem_wb_lane
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  wb_op_e                op,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_valid <= 1'b0;
            wb_wd    <= REG_ADDR_W'(NOPRegAddr);
            wb_wreg  <= WriteDisable;
            wb_wdata <= DATA_W'(ZeroWord);
        end else begin
            unique case (op)
                OpFlush, OpBubble: begin
                    wb_valid <= 1'b0;
                    wb_wd    <= REG_ADDR_W'(NOPRegAddr);
                    wb_wreg  <= WriteDisable;
                    wb_wdata <= DATA_W'(ZeroWord);
                end
                OpAdvance: begin
                    wb_valid <= mem_valid;
                    wb_wd    <= mem_wd;
                    // An invalid lane must never write the regfile.
                    wb_wreg  <= mem_wreg & mem_valid;
                    wb_wdata <= mem_wdata;
                end
                OpHold: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: LANES write-back lanes, HI/LO, LLbit and CP0 fields, retire counter.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LANES      = 1,
    parameter int unsigned CP0_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    mem_wb_pipe_if.slave     bus,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_op_e op;
    assign op = decode_op(flush, stall);

    logic [LANES-1:0]            lane_valid;
    logic [LANES*REG_ADDR_W-1:0] lane_wd;
    logic [LANES-1:0]            lane_wreg;
    logic [LANES*DATA_W-1:0]     lane_wdata;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_wb_lane #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .op        (op),
            .mem_valid (bus.mem_valid[i]),
            .mem_wd    (bus.mem_wd[i*REG_ADDR_W +: REG_ADDR_W]),
            .mem_wreg  (bus.mem_wreg[i]),
            .mem_wdata (bus.mem_wdata[i*DATA_W +: DATA_W]),
            .wb_valid  (lane_valid[i]),
            .wb_wd     (lane_wd[i*REG_ADDR_W +: REG_ADDR_W]),
            .wb_wreg   (lane_wreg[i]),
            .wb_wdata  (lane_wdata[i*DATA_W +: DATA_W])
        );
    end

    assign bus.wb_valid = lane_valid;
    assign bus.wb_wd    = lane_wd;
    assign bus.wb_wreg  = lane_wreg;
    assign bus.wb_wdata = lane_wdata;

    logic [CNT_W-1:0] retire_cnt_q;
    logic             lane0_valid;
    assign lane0_valid = bus.mem_valid[0];

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            bus.wb_hi          <= DATA_W'(ZeroWord);
            bus.wb_lo          <= DATA_W'(ZeroWord);
            bus.wb_whilo       <= WriteDisable;
            bus.wb_llbit_we    <= WriteDisable;
            bus.wb_llbit_value <= 1'b0;
            bus.wb_cp0_we      <= WriteDisable;
            bus.wb_cp0_waddr   <= '0;
            bus.wb_cp0_data    <= DATA_W'(ZeroWord);
            retire_cnt_q       <= '0;
        end else begin
            unique case (op)
                OpFlush, OpBubble: begin
                    bus.wb_hi          <= DATA_W'(ZeroWord);
                    bus.wb_lo          <= DATA_W'(ZeroWord);
                    bus.wb_whilo       <= WriteDisable;
                    bus.wb_llbit_we    <= WriteDisable;
                    bus.wb_llbit_value <= 1'b0;
                    bus.wb_cp0_we      <= WriteDisable;
                    bus.wb_cp0_waddr   <= '0;
                    bus.wb_cp0_data    <= DATA_W'(ZeroWord);
                end
                OpAdvance: begin
                    bus.wb_hi          <= bus.mem_hi;
                    bus.wb_lo          <= bus.mem_lo;
                    bus.wb_whilo       <= bus.mem_whilo & lane0_valid;
                    bus.wb_llbit_we    <= bus.mem_llbit_we & lane0_valid;
                    bus.wb_llbit_value <= bus.mem_llbit_value;
                    bus.wb_cp0_we      <= bus.mem_cp0_we & lane0_valid;
                    bus.wb_cp0_waddr   <= bus.mem_cp0_waddr;
                    bus.wb_cp0_data    <= bus.mem_cp0_data;
                    // Wraps modulo 2^CNT_W by design.
                    retire_cnt_q       <= retire_cnt_q + CNT_W'(popcount4(4'(bus.mem_valid)));
                end
                OpHold: begin
                end
            endcase
        end
    end

    assign retire_cnt = retire_cnt_q;

    illegal_stall_a: assert property (@(posedge clk) disable iff (rst)
        !(stall[StallWbBit] && !stall[StallMemBit]));

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM→WB pipeline register, the successor to the single-lane MEM/WB latch.
- Carries LANES write-back channels plus HI/LO, LLbit and CP0 write fields.
- Honours the ctrl block's stall vector and exception flush, and tracks a per-lane valid bit.
- Keeps a retired-instruction counter.
- Sits between the mem stage and regfile/hilo_reg/cp0; its outputs also feed the forwarding network.

Parameters:
DATA_W, 32, width of GPR/HI/LO/CP0 data
REG_ADDR_W, 5, GPR address width
LANES, 1, number of parallel write-back lanes (1..4)
CP0_ADDR_W, 5, CP0 register address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high (RstEnable = 1)
stall  in  6  ctrl stall vector; bit4 = mem stage stalled, bit5 = wb stage stalled
flush  in  1  exception flush from ctrl
mem_valid  in  LANES  lane carries a real instruction
mem_wd  in  LANES*REG_ADDR_W  destination GPR per lane
mem_wreg  in  LANES  GPR write enable per lane
mem_wdata  in  LANES*DATA_W  GPR write data per lane
mem_hi, mem_lo  in  DATA_W each  HI/LO data (lane 0 only)
mem_whilo  in  1  HI/LO write enable
mem_llbit_we, mem_llbit_value  in  1 each  LLbit update
mem_cp0_we  in  1  CP0 write enable
mem_cp0_waddr  in  CP0_ADDR_W  CP0 write address
mem_cp0_data  in  DATA_W  CP0 write data
wb_valid, wb_wd, wb_wreg, wb_wdata  out  same widths as mem_*  registered lane fields
wb_hi, wb_lo, wb_whilo, wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr, wb_cp0_data  out  registered copies
retire_cnt  out  CNT_W  count of valid instructions committed to WB

Behaviour:
- All registers use non-blocking assignment and update on posedge clk only.
- Reset (rst=1):
  - wb_valid=0, wb_wd=NOPRegAddr (0), wb_wreg=0, wb_wdata=0.
  - wb_hi=wb_lo=0, wb_whilo=0, llbit_we/value=0, cp0_we=0, cp0_waddr=0, cp0_data=0.
  - retire_cnt=0.
  - Reset overrides flush and stall.
- Priority each cycle: rst > flush > bubble > advance > hold.
- Flush (flush=1): every output loads its reset value; retire_cnt is not incremented.
- Bubble (stall[4]=1, stall[5]=0): mem is held but wb proceeds. All outputs load reset values, so no write enables are asserted in WB.
- Advance (stall[4]=0): every wb_* field loads its mem_* input. Latency is exactly 1 cycle.
- Hold (stall[4]=1, stall[5]=1): all outputs keep their value; retire_cnt unchanged.
- Write-enable gating: wb_wreg[i] = mem_wreg[i] & mem_valid[i]. whilo, llbit_we and cp0_we are gated by mem_valid[0]. An invalid lane never produces a write.
- retire_cnt:
  - On advance, add popcount(mem_valid).
  - Wraps modulo 2^CNT_W with no saturation.
- Stall vector: stall[5]=1 with stall[4]=0 is illegal from ctrl. It is treated as advance, and an assertion flags it in simulation.
- Same-address lanes: two lanes may target the same wd in one cycle. The latch passes both unchanged; resolving the conflict (highest lane wins) is the regfile's job.
- Reset mid-stall: state is discarded and the block resumes in the advance state, since it holds no other state.

Decomposition:
- Shared defines: RstEnable, WriteEnable/Disable, ZeroWord, NOPRegAddr, Stop/NoStop, stall bit indices.
- One natural sub-module, mem_wb_lane: the per-lane valid/wd/wreg/wdata register with the bubble/hold/advance logic, instantiated LANES times in a generate loop.
- Shared fields (HI/LO, LLbit, CP0) and the counter live in the top module.
- Popcount is a function in the shared include.

Test Plan:
1. Reset: rst=1 for 2 cycles with mem_wdata=0xDEADBEEF, mem_wreg=1 → all wb_* = 0 and retire_cnt = 0. Release rst → the next edge shows wb_wdata = 0xDEADBEEF.
2. Advance, LANES=2: valid=2'b11, wd={5'd3,5'd7}, wdata={0x11,0x22}, wreg=2'b11 → next cycle the wb fields match and retire_cnt += 2. Then valid=2'b01 → wb_wreg=2'b01 and retire_cnt += 1.
3. Bubble: stall=6'b010000 with mem_wreg=1 → next cycle wb_wreg=0, wb_wd=0, wb_valid=0, and retire_cnt unchanged.
4. Hold: stall=6'b110000 for 3 cycles after loading wdata=0x1234 while the inputs change → wb_wdata stays 0x1234. Release → the new data appears 1 cycle later.
5. Flush vs stall: flush=1 together with stall=6'b000000 → outputs cleared. Flush together with hold → outputs still cleared.
6. Counter wrap: CNT_W=4, 17 single-lane valid advances → retire_cnt = 1. HI/LO path: whilo=1 with valid[0]=0 → wb_whilo = 0.
